// File: rtl/cpu_pipeline_fwd.sv
// cpu_pipeline_fwd: 5-stage in-order core (fetch/decode/execute/memory/writeback)
// with operand forwarding, load-use interlock and a ready-handshaked data bus.
// Optional feature macro: CPU_PIPELINE_FWD_FORWARDING_EN (bypass network and
// load-use interlock). Without it, decode interlocks on every EX/MEM hazard.
module cpu_pipeline_fwd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int REG_COUNT  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic [31:0]           i_instruction,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_req,
  output logic                  o_rw,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_debug_stall,
  output logic                  o_debug_freeze,
  output logic [31:0]           o_debug_ir
);
  localparam int RS_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

`ifdef CPU_PIPELINE_FWD_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;

  // Bypass select: youngest producer (EX/MEM) wins over MEM/WB, then the base value.
  function automatic logic [DATA_WIDTH-1:0] fwd_val(
      input logic [RS_W-1:0]       idx,
      input logic [DATA_WIDTH-1:0] base,
      input logic                  mem_en,
      input logic [RS_W-1:0]       mem_rd,
      input logic [DATA_WIDTH-1:0] mem_val,
      input logic                  wb_en,
      input logic [RS_W-1:0]       wb_rd,
      input logic [DATA_WIDTH-1:0] wb_val);
    logic [DATA_WIDTH-1:0] v;
    if (mem_en && (mem_rd == idx)) v = mem_val;
    else if (wb_en && (wb_rd == idx)) v = wb_val;
    else v = base;
    return v;
  endfunction

  // Fetch / IF-ID
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_ir;
  // ID-EX
  logic [2:0]            r_ex_op;
  logic                  r_ex_we;
  logic [RS_W-1:0]       r_ex_rd, r_ex_rs1, r_ex_rs2;
  logic [DATA_WIDTH-1:0] r_ex_v1, r_ex_v2, r_ex_vd, r_ex_imm;
  // EX-MEM (bus outputs are registered here)
  logic                  r_mem_we, r_mem_lw, r_mem_req, r_mem_rw;
  logic [RS_W-1:0]       r_mem_rd;
  logic [DATA_WIDTH-1:0] r_mem_alu, r_mem_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  // MEM-WB
  logic                  r_wb_we;
  logic [RS_W-1:0]       r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_val;
  // Register file
  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  logic [2:0]            w_id_op;
  logic                  w_id_use1, w_id_use2, w_id_used, w_id_we;
  logic [RS_W-1:0]       w_id_rd, w_id_rs1, w_id_rs2;
  logic [DATA_WIDTH-1:0] w_id_imm, w_id_v1, w_id_v2, w_id_vd;
  logic                  w_hit_ex, w_hit_mem, w_hz, w_stall, w_freeze, w_wb_wr;
  logic                  w_mem_fwd, w_wb_fwd, w_ex_mem_op;
  logic [DATA_WIDTH-1:0] w_a, w_b, w_rs2v, w_sd, w_alu;

  assign w_id_rd  = r_ir[20 +: RS_W];
  assign w_id_rs1 = r_ir[16 +: RS_W];
  assign w_id_rs2 = r_ir[12 +: RS_W];
  assign w_id_imm = {{(DATA_WIDTH-16){1'b0}}, r_ir[15:0]};

  // Opcode decode; unknown opcodes execute as NOP.
  always_comb begin
    w_id_op = OP_NOP;
    case (r_ir[31:24])
      8'd1:    w_id_op = OP_LW;
      8'd2:    w_id_op = OP_SW;
      8'd3:    w_id_op = OP_ADD;
      8'd4:    w_id_op = OP_SUB;
      8'd5:    w_id_op = OP_ADDI;
      default: w_id_op = OP_NOP;
    endcase
  end

  assign w_id_use1 = (w_id_op != OP_NOP);
  assign w_id_use2 = (w_id_op == OP_ADD) || (w_id_op == OP_SUB);
  assign w_id_used = (w_id_op == OP_SW);
  assign w_id_we   = (w_id_op == OP_LW) || (w_id_op == OP_ADD) ||
                     (w_id_op == OP_SUB) || (w_id_op == OP_ADDI);

  // A WB write is suppressed while the pipe is frozen, and is visible to decode the same cycle.
  assign w_freeze = r_mem_req & ~i_ready;
  assign w_wb_wr  = r_wb_we & ~w_freeze;
  assign w_id_v1  = (w_wb_wr && (r_wb_rd == w_id_rs1)) ? r_wb_val : r_regs[w_id_rs1];
  assign w_id_v2  = (w_wb_wr && (r_wb_rd == w_id_rs2)) ? r_wb_val : r_regs[w_id_rs2];
  assign w_id_vd  = (w_wb_wr && (r_wb_rd == w_id_rd))  ? r_wb_val : r_regs[w_id_rd];

  // Decode interlock: load-use only with bypass, any in-flight EX/MEM producer without it.
  always_comb begin
    w_hit_ex  = (w_id_use1 && (w_id_rs1 == r_ex_rd)) || (w_id_use2 && (w_id_rs2 == r_ex_rd)) ||
                (w_id_used && (w_id_rd == r_ex_rd));
    w_hit_mem = (w_id_use1 && (w_id_rs1 == r_mem_rd)) || (w_id_use2 && (w_id_rs2 == r_mem_rd)) ||
                (w_id_used && (w_id_rd == r_mem_rd));
    if (FWD_EN) w_hz = (r_ex_op == OP_LW) && w_hit_ex;
    else        w_hz = (r_ex_we && w_hit_ex) || (r_mem_we && w_hit_mem);
  end

  // Freeze dominates: a stall is only reported while the pipe is moving.
  assign w_stall = w_hz & ~w_freeze;

  // Execute: operand bypass and ALU. Loads in EX/MEM never forward (interlocked instead).
  assign w_mem_fwd   = FWD_EN & r_mem_we & ~r_mem_lw;
  assign w_wb_fwd    = FWD_EN & r_wb_we;
  assign w_ex_mem_op = (r_ex_op == OP_LW) || (r_ex_op == OP_SW);

  // ALU operand selection and add/subtract.
  always_comb begin
    w_a    = fwd_val(r_ex_rs1, r_ex_v1, w_mem_fwd, r_mem_rd, r_mem_alu, w_wb_fwd, r_wb_rd, r_wb_val);
    w_rs2v = fwd_val(r_ex_rs2, r_ex_v2, w_mem_fwd, r_mem_rd, r_mem_alu, w_wb_fwd, r_wb_rd, r_wb_val);
    w_sd   = fwd_val(r_ex_rd,  r_ex_vd, w_mem_fwd, r_mem_rd, r_mem_alu, w_wb_fwd, r_wb_rd, r_wb_val);
    if ((r_ex_op == OP_ADD) || (r_ex_op == OP_SUB)) w_b = w_rs2v;
    else w_b = r_ex_imm;
    if (r_ex_op == OP_SUB) w_alu = w_a - w_b;
    else w_alu = w_a + w_b;
  end

  // Pipeline registers: freeze holds everything, stall holds fetch and bubbles execute.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= {ADDR_WIDTH{1'b0}};   r_ir <= 32'h0;
      r_ex_op <= OP_NOP;            r_ex_we <= 1'b0;
      r_ex_rd <= {RS_W{1'b0}};      r_ex_rs1 <= {RS_W{1'b0}};   r_ex_rs2 <= {RS_W{1'b0}};
      r_ex_v1 <= {DATA_WIDTH{1'b0}}; r_ex_v2 <= {DATA_WIDTH{1'b0}};
      r_ex_vd <= {DATA_WIDTH{1'b0}}; r_ex_imm <= {DATA_WIDTH{1'b0}};
      r_mem_we <= 1'b0;  r_mem_lw <= 1'b0;  r_mem_req <= 1'b0;  r_mem_rw <= 1'b0;
      r_mem_rd <= {RS_W{1'b0}};     r_mem_alu <= {DATA_WIDTH{1'b0}};
      r_mem_wdata <= {DATA_WIDTH{1'b0}}; r_mem_addr <= {ADDR_WIDTH{1'b0}};
      r_wb_we <= 1'b0;   r_wb_rd <= {RS_W{1'b0}};   r_wb_val <= {DATA_WIDTH{1'b0}};
    end else if (!w_freeze) begin
      if (!w_stall) begin
        r_pc <= r_pc + ADDR_WIDTH'(3'd4);
        r_ir <= i_instruction;
        r_ex_op <= w_id_op;   r_ex_we <= w_id_we;
        r_ex_rd <= w_id_rd;   r_ex_rs1 <= w_id_rs1;  r_ex_rs2 <= w_id_rs2;
        r_ex_v1 <= w_id_v1;   r_ex_v2 <= w_id_v2;    r_ex_vd <= w_id_vd;
        r_ex_imm <= w_id_imm;
      end else begin
        r_ex_op <= OP_NOP;
        r_ex_we <= 1'b0;
      end
      r_mem_we    <= r_ex_we;
      r_mem_lw    <= (r_ex_op == OP_LW);
      r_mem_rd    <= r_ex_rd;
      r_mem_alu   <= w_alu;
      r_mem_req   <= w_ex_mem_op;
      r_mem_rw    <= (r_ex_op == OP_SW);
      r_mem_addr  <= w_ex_mem_op ? w_alu[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};
      r_mem_wdata <= (r_ex_op == OP_SW) ? w_sd : {DATA_WIDTH{1'b0}};
      r_wb_we     <= r_mem_we;
      r_wb_rd     <= r_mem_rd;
      r_wb_val    <= r_mem_lw ? i_data : r_mem_alu;
    end
  end

  // Register file write port (writeback stage).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= {DATA_WIDTH{1'b0}};
    end else if (w_wb_wr) begin
      r_regs[r_wb_rd] <= r_wb_val;
    end
  end

  assign o_pc           = r_pc;
  assign o_req          = r_mem_req;
  assign o_rw           = r_mem_rw;
  assign o_address      = r_mem_addr;
  assign o_data         = r_mem_wdata;
  assign o_debug_stall  = w_stall;
  assign o_debug_freeze = w_freeze;
  assign o_debug_ir     = r_ir;
endmodule

// File: tb/tb_cpu_pipeline_fwd.sv
// Self-checking bench for cpu_pipeline_fwd: directed programs, a bus scoreboard
// checked by a monitor process, plus direct checks on reset, freeze and PC wrap.
module tb_cpu_pipeline_fwd;
  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] o_pc, o_address;
  logic [31:0] i_instruction, o_data, i_data, o_debug_ir;
  logic        o_req, o_rw, i_ready, o_debug_stall, o_debug_freeze;

  logic [31:0] rom [0:63];
  int          wait_cfg = 0;
  int          ready_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed { logic rw; logic [15:0] addr; logic [31:0] data; } bus_t;
  bus_t sb_q[$];

  always #5 clk = ~clk;

  cpu_pipeline_fwd dut (
    .i_clk(clk), .i_reset(i_reset), .o_pc(o_pc), .i_instruction(i_instruction),
    .o_address(o_address), .o_req(o_req), .o_rw(o_rw), .o_data(o_data),
    .i_data(i_data), .i_ready(i_ready), .o_debug_stall(o_debug_stall),
    .o_debug_freeze(o_debug_freeze), .o_debug_ir(o_debug_ir));

  // Instruction ROM (combinational), NOP outside the first 64 words.
  assign i_instruction = (o_pc[15:8] == 8'h00) ? rom[o_pc[7:2]] : 32'h0;
  // Data memory: one preset word at 0x10.
  assign i_data  = (o_address == 16'h0010) ? 32'hDEADBEEF : 32'h0BAD0BAD;
  assign i_ready = (ready_cnt >= wait_cfg);

  // Wait-state generator: each access waits wait_cfg cycles before ready.
  always @(posedge clk) begin
    if (o_req && !i_ready) ready_cnt <= ready_cnt + 1;
    else ready_cnt <= 0;
  end

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [7:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 12'h000};
  endfunction

  function automatic bus_t mk(input logic rw, input logic [15:0] addr, input logic [31:0] data);
    bus_t b;
    b.rw = rw; b.addr = addr; b.data = data;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    bus_t e;
    forever begin
      @(negedge clk);
      if (!i_reset && o_req && i_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got rw=%0b addr=%0h data=%0h, expected no access",
                   o_rw, o_address, o_data);
        end else begin
          e = sb_q.pop_front();
          check("bus_rw", 64'(o_rw), 64'(e.rw));
          check("bus_addr", 64'(o_address), 64'(e.addr));
          if (e.rw) check("bus_wdata", 64'(o_data), 64'(e.data));
        end
      end
    end
  endtask

  task automatic start_prog();
    @(negedge clk);
    i_reset = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic run_count(input int n, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_debug_stall) stalls++;
    end
  endtask

  task automatic wait_req(input int bound, output logic found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_req) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  int          st;
  logic        found;
  logic [15:0] pc0;

  initial begin
    i_reset = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    fork
      monitor_loop();
    join_none

    // Program A: independent and dependent ALU ops, dependent store data.
    start_prog();
    rom[0] = enc(8'd5, 4'd1, 4'd0, 16'd5);
    rom[1] = enc(8'd5, 4'd2, 4'd0, 16'd7);
    rom[2] = enc_r(8'd3, 4'd3, 4'd1, 4'd2);
    rom[3] = enc_r(8'd3, 4'd5, 4'd3, 4'd3);
    rom[4] = enc(8'd2, 4'd5, 4'd0, 16'h0104);
    rom[5] = enc(8'd2, 4'd3, 4'd0, 16'h0100);
    sb_q.push_back(mk(1'b1, 16'h0104, 32'h18));
    sb_q.push_back(mk(1'b1, 16'h0100, 32'h0C));
    repeat (2) @(negedge clk);
    check("rst_pc", 64'(o_pc), 64'(16'h0));
    check("rst_req", 64'(o_req), 64'(1'b0));
    check("rst_rw", 64'(o_rw), 64'(1'b0));
    check("rst_addr", 64'(o_address), 64'(16'h0));
    check("rst_data", 64'(o_data), 64'(32'h0));
    check("rst_stall", 64'(o_debug_stall), 64'(1'b0));
    check("rst_freeze", 64'(o_debug_freeze), 64'(1'b0));
    check("rst_ir", 64'(o_debug_ir), 64'(32'h0));
    i_reset = 1'b0;
    @(negedge clk);
    check("first_fetch_pc", 64'(o_pc), 64'(16'h4));
    check("first_fetch_ir", 64'(o_debug_ir), 64'(enc(8'd5, 4'd1, 4'd0, 16'd5)));
    run_count(30, st);
`ifdef CPU_PIPELINE_FWD_FORWARDING_EN
    check("A_stalls", 64'(st), 64'(0));
`else
    check("A_stalls_nonzero", 64'(st != 0), 64'(1'b1));
`endif
    check("A_pending", 64'(sb_q.size()), 64'(0));

    // Program B: registers cleared by reset, then load-use.
    start_prog();
    rom[0] = enc(8'd2, 4'd3, 4'd0, 16'h0044);
    rom[1] = enc(8'd5, 4'd1, 4'd0, 16'h0010);
    rom[2] = enc(8'd1, 4'd2, 4'd1, 16'h0000);
    rom[3] = enc_r(8'd3, 4'd3, 4'd2, 4'd2);
    rom[7] = enc(8'd2, 4'd3, 4'd0, 16'h0020);
    sb_q.push_back(mk(1'b1, 16'h0044, 32'h0));
    sb_q.push_back(mk(1'b0, 16'h0010, 32'h0));
    sb_q.push_back(mk(1'b1, 16'h0020, 32'hBD5B7DDE));
    release_reset();
    run_count(30, st);
`ifdef CPU_PIPELINE_FWD_FORWARDING_EN
    check("B_stalls", 64'(st), 64'(1));
`else
    check("B_stalls_nonzero", 64'(st != 0), 64'(1'b1));
`endif
    check("B_pending", 64'(sb_q.size()), 64'(0));

    // Program C: store with 3 wait states, then SUB producing all ones.
    wait_cfg = 3;
    start_prog();
    rom[0]  = enc(8'd5, 4'd1, 4'd0, 16'h0010);
    rom[1]  = enc(8'd5, 4'd2, 4'd0, 16'h0055);
    rom[5]  = enc(8'd2, 4'd2, 4'd1, 16'h0004);
    rom[6]  = enc(8'd5, 4'd1, 4'd0, 16'h0001);
    rom[7]  = enc_r(8'd4, 4'd4, 4'd0, 4'd1);
    rom[11] = enc(8'd2, 4'd4, 4'd0, 16'h0030);
    sb_q.push_back(mk(1'b1, 16'h0014, 32'h55));
    sb_q.push_back(mk(1'b1, 16'h0030, 32'hFFFFFFFF));
    release_reset();
    wait_req(40, found);
    check("C_req_seen", 64'(found), 64'(1'b1));
    pc0 = o_pc;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("C_req", 64'(o_req), 64'(1'b1));
      check("C_rw", 64'(o_rw), 64'(1'b1));
      check("C_addr", 64'(o_address), 64'(16'h0014));
      check("C_data", 64'(o_data), 64'(32'h55));
      check("C_pc_hold", 64'(o_pc), 64'(pc0));
      check("C_freeze", 64'(o_debug_freeze), 64'(k < 3));
    end
    @(negedge clk);
    check("C_req_drop", 64'(o_req), 64'(1'b0));
    run_count(40, st);
    check("C_pending", 64'(sb_q.size()), 64'(0));

    // Program D: reset during a stalled store abandons it.
    wait_cfg = 1000;
    start_prog();
    rom[0] = enc(8'd2, 4'd0, 4'd0, 16'h0050);
    release_reset();
    wait_req(20, found);
    check("D_req_seen", 64'(found), 64'(1'b1));
    repeat (2) @(negedge clk);
    check("D_req_before_rst", 64'(o_req), 64'(1'b1));
    i_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("D_req_after_rst", 64'(o_req), 64'(1'b0));
    end

    // PC wrap: run NOPs until PC reaches the top of the address space.
    wait_cfg = 0;
    start_prog();
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (o_pc == 16'hFFFC) begin
        found = 1'b1;
        break;
      end
    end
    check("wrap_reach_max", 64'(found), 64'(1'b1));
    @(negedge clk);
    check("wrap_to_zero", 64'(o_pc), 64'(16'h0));
    check("final_pending", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
